// File: rtl/lob_pkg.sv
// lob_pkg: operation codes, response status codes and dispatcher FSM states
// shared by the order-book message dispatcher and its testbench.
package lob_pkg;

    typedef enum logic [2:0] {
        OP_ADD             = 3'd0,
        OP_EXECUTE         = 3'd1,
        OP_CANCEL          = 3'd2,
        OP_DELETE          = 3'd3,
        OP_BEST_LIMIT      = 3'd4,
        OP_VOLUME_AT_LIMIT = 3'd5
    } op_e;

    localparam logic [1:0] STAT_OK      = 2'b00;
    localparam logic [1:0] STAT_ILLEGAL = 2'b01;
    localparam logic [1:0] STAT_TIMEOUT = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_e;

endpackage

// File: rtl/lob_msg_fifo.sv
// lob_msg_fifo: message queue, DEPTH entries of WIDTH bits, no bypass.
// Ports: push/push_data in, pop/pop_data out (head), full, empty.
module lob_msg_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 52
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full     = (count_q == (AW+1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign pop_data = mem_q[rd_ptr_q];

    // Power-of-two depth: pointers wrap naturally.
    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/lob_msg_dispatcher.sv
// lob_msg_dispatcher: queues order-book messages, starts the engine for each
// message type, waits for done or timeout and returns one response per message.
module lob_msg_dispatcher
    import lob_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int TYPE_W     = 3,
    parameter int N_OPS      = 6,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [TYPE_W-1:0]       in_type,
    input  logic                    in_side,
    input  logic [DATA_W-1:0]       in_id,
    input  logic [DATA_W-1:0]       in_size,
    input  logic [DATA_W-1:0]       in_limit,
    output logic [N_OPS-1:0]        op_start,
    output logic                    op_side,
    output logic [DATA_W-1:0]       op_id,
    output logic [DATA_W-1:0]       op_size,
    output logic [DATA_W-1:0]       op_limit,
    input  logic [N_OPS-1:0]        op_done,
    input  logic [N_OPS*DATA_W-1:0] op_out,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [DATA_W-1:0]       res_data,
    output logic [1:0]              res_status,
    output logic [TYPE_W-1:0]       res_type,
    output logic                    busy
);

    localparam int MSG_W = TYPE_W + 1 + 3*DATA_W;
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [TYPE_W:0]  N_OPS_X  = (TYPE_W+1)'(N_OPS);

    state_e            state_q, state_d;
    logic [TYPE_W-1:0] typ_q, typ_d;
    logic              side_q, side_d;
    logic [DATA_W-1:0] id_q, id_d;
    logic [DATA_W-1:0] size_q, size_d;
    logic [DATA_W-1:0] limit_q, limit_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [DATA_W-1:0] res_data_q, res_data_d;
    logic [1:0]        res_status_q, res_status_d;

    logic              pop, full, empty;
    logic [MSG_W-1:0]  head;
    logic [N_OPS-1:0]  sel;
    logic [DATA_W-1:0] eng_out [N_OPS];
    logic [DATA_W-1:0] sel_out;
    logic              sel_done;
    logic              legal;

    lob_msg_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (MSG_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (in_valid),
        .push_data ({in_type, in_side, in_id, in_size, in_limit}),
        .pop       (pop),
        .pop_data  (head),
        .full      (full),
        .empty     (empty)
    );

    for (genvar k = 0; k < N_OPS; k++) begin : g_eng
        assign sel[k]      = (typ_q == TYPE_W'(k));
        assign op_start[k] = (state_q == S_ISSUE) && sel[k];
        assign eng_out[k]  = op_out[k*DATA_W +: DATA_W] & {DATA_W{sel[k]}};
    end

    // At most one slice survives the mask, so OR-ing acts as the mux.
    always_comb begin
        sel_out = '0;
        for (int k = 0; k < N_OPS; k++) sel_out = sel_out | eng_out[k];
    end

    assign sel_done = |(op_done & sel);
    assign legal    = ({1'b0, typ_q} < N_OPS_X);

    always_comb begin
        state_d      = state_q;
        typ_d        = typ_q;
        side_d       = side_q;
        id_d         = id_q;
        size_d       = size_q;
        limit_d      = limit_q;
        timer_d      = timer_q;
        res_data_d   = res_data_q;
        res_status_d = res_status_q;
        pop          = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop = 1'b1;
                    {typ_d, side_d, id_d, size_d, limit_d} = head;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (legal) begin
                    timer_d = '0;
                    state_d = S_WAIT;
                end else begin
                    res_data_d   = '0;
                    res_status_d = STAT_ILLEGAL;
                    state_d      = S_RESP;
                end
            end
            S_WAIT: begin
                // Done wins over a timeout landing in the same cycle.
                if (sel_done) begin
                    res_data_d   = sel_out;
                    res_status_d = STAT_OK;
                    state_d      = S_RESP;
                end else if (timer_q == TMR_LAST) begin
                    res_data_d   = '0;
                    res_status_d = STAT_TIMEOUT;
                    state_d      = S_RESP;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_RESP: begin
                if (res_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            typ_q        <= '0;
            side_q       <= 1'b0;
            id_q         <= '0;
            size_q       <= '0;
            limit_q      <= '0;
            timer_q      <= '0;
            res_data_q   <= '0;
            res_status_q <= STAT_OK;
        end else begin
            state_q      <= state_d;
            typ_q        <= typ_d;
            side_q       <= side_d;
            id_q         <= id_d;
            size_q       <= size_d;
            limit_q      <= limit_d;
            timer_q      <= timer_d;
            res_data_q   <= res_data_d;
            res_status_q <= res_status_d;
        end
    end

    assign in_ready   = !full;
    assign op_side    = side_q;
    assign op_id      = id_q;
    assign op_size    = size_q;
    assign op_limit   = limit_q;
    assign res_valid  = (state_q == S_RESP);
    assign res_data   = res_data_q;
    assign res_status = res_status_q;
    assign res_type   = typ_q;
    assign busy       = !empty || (state_q != S_IDLE);

endmodule

// File: tb/tb_lob_msg_dispatcher.sv
// tb_lob_msg_dispatcher: directed and random messages against a queue-based
// model of per-message outcome (engine delay/value -> status, data, latency).
module tb_lob_msg_dispatcher;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid, in_ready, in_side;
    logic [2:0]  in_type;
    logic [15:0] in_id, in_size, in_limit;
    logic [5:0]  op_start, op_done;
    logic        op_side;
    logic [15:0] op_id, op_size, op_limit;
    logic [95:0] op_out;
    logic        res_valid, res_ready, busy;
    logic [15:0] res_data;
    logic [1:0]  res_status;
    logic [2:0]  res_type;

    lob_msg_dispatcher dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_type    (in_type),
        .in_side    (in_side),
        .in_id      (in_id),
        .in_size    (in_size),
        .in_limit   (in_limit),
        .op_start   (op_start),
        .op_side    (op_side),
        .op_id      (op_id),
        .op_size    (op_size),
        .op_limit   (op_limit),
        .op_done    (op_done),
        .op_out     (op_out),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_status (res_status),
        .res_type   (res_type),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  typ;
        logic        side;
        logic [15:0] id;
        logic [15:0] size;
        logic [15:0] limit;
        int          dly;
        logic [15:0] val;
    } msg_t;

    msg_t        pend_q[$];
    int          n_total = 0;
    int          n_bad   = 0;
    int          nresp   = 0;
    int          cyc     = 0;
    int          nxt_dly = 0;
    logic [15:0] nxt_val = '0;
    logic        rand_rdy = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // dly 0 = engine never answers; 1..255 = done that many cycles after start.
    function automatic logic [20:0] exp_rsp(msg_t m);
        if (m.typ >= 3'd6) return {m.typ, 2'b01, 16'h0};
        if (m.dly == 0)    return {m.typ, 2'b10, 16'h0};
        return {m.typ, 2'b00, m.val};
    endfunction

    // Engine model and response monitor.
    initial begin
        msg_t        m;
        logic [5:0]  od, ev;
        logic [95:0] oo;
        int          eng_cnt = 0, eng_tgt = 0, start_cyc = 0;
        logic [15:0] eng_val = '0;
        logic        inflight = 1'b0;
        logic        prev_valid = 1'b0, prev_hs = 1'b0, hs;
        logic [15:0] prev_data = '0;
        logic [1:0]  prev_st = '0;
        logic [2:0]  prev_ty = '0;
        op_done = '0;
        op_out  = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                op_done = '0;
                pend_q.delete();
                eng_cnt = 0;
                inflight = 1'b0;
                prev_valid = 1'b0;
                prev_hs = 1'b0;
                continue;
            end
            cyc++;
            od = 6'($urandom);
            if (pend_q.size() > 0 && pend_q[0].typ < 3'd6)
                od[pend_q[0].typ] = 1'b0;
            for (int k = 0; k < 6; k++) oo[k*16 +: 16] = 16'($urandom);
            if (eng_cnt > 0) begin
                eng_cnt--;
                if (eng_cnt == 1) od[(eng_tgt + 2) % 6] = 1'b1;
                if (eng_cnt == 0) begin
                    od[eng_tgt] = 1'b1;
                    oo[eng_tgt*16 +: 16] = eng_val;
                end
            end
            op_done = od;
            op_out  = oo;

            if (op_start != '0) begin
                chk("start_dup", 64'(inflight), 0);
                if (pend_q.size() == 0) chk("start_none", 64'(op_start), 0);
                else begin
                    m  = pend_q[0];
                    ev = 6'(1) << m.typ;
                    chk("start_vec", 64'(op_start), 64'(ev));
                    chk("start_fld", {op_side, op_id, op_size, op_limit},
                        {m.side, m.id, m.size, m.limit});
                    eng_cnt   = m.dly;
                    eng_tgt   = int'(m.typ);
                    eng_val   = m.val;
                    inflight  = 1'b1;
                    start_cyc = cyc;
                end
            end

            if (prev_valid && !prev_hs)
                chk("hold", {res_valid, res_data, res_status, res_type},
                    {1'b1, prev_data, prev_st, prev_ty});
            if (res_valid && !prev_valid && pend_q.size() > 0) begin
                m = pend_q[0];
                chk("started", 64'(inflight), 64'(m.typ < 3'd6));
                if (m.typ < 3'd6)
                    chk("lat", 64'(cyc - start_cyc),
                        64'((m.dly == 0) ? 256 : m.dly + 1));
            end
            hs = res_valid && res_ready;
            if (hs) begin
                if (pend_q.size() == 0) chk("spurious", 64'(res_valid), 0);
                else begin
                    m = pend_q.pop_front();
                    chk("rsp", {res_type, res_status, res_data}, exp_rsp(m));
                    inflight = 1'b0;
                    nresp++;
                end
            end
            prev_valid = res_valid;
            prev_hs    = hs;
            prev_data  = res_data;
            prev_st    = res_status;
            prev_ty    = res_type;

            if (in_valid && in_ready) begin
                m.typ = in_type;  m.side = in_side;
                m.id = in_id;     m.size = in_size;
                m.limit = in_limit;
                m.dly = nxt_dly;  m.val = nxt_val;
                pend_q.push_back(m);
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) res_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got stuck expected finish");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [2:0] t, input logic [15:0] id,
                        input logic [15:0] sz, input logic [15:0] lim,
                        input int dly, input logic [15:0] val);
        int n = 0;
        @(posedge clk);
        #1;
        in_valid = 1'b1; in_type = t; in_side = 1'($urandom);
        in_id = id; in_size = sz; in_limit = lim;
        nxt_dly = dly; nxt_val = val;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            if (++n > 2000) begin
                chk("send_to", 64'(in_ready), 1);
                break;
            end
        end
    endtask

    task automatic rel();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        forever begin
            @(negedge clk);
            if (pend_q.size() == 0 && !busy) break;
            if (++n > max) begin
                chk("idle_to", {busy, pend_q.size() != 0}, 0);
                break;
            end
        end
    endtask

    initial begin
        int n0, n;
        in_valid = 0; in_type = 0; in_side = 0;
        in_id = 0; in_size = 0; in_limit = 0;
        res_ready = 1'b1;
        #1 rst = 1'b0;
        #1;
        chk("rst0_ready", 64'(in_ready), 1);
        chk("rst0_busy", 64'(busy), 0);
        chk("rst0_valid", 64'(res_valid), 0);
        chk("rst0_start", 64'(op_start), 0);
        #20 rst = 1'b1;

        // Single ADD, engine answers 3 cycles after start.
        n0 = nresp;
        send(3'd0, 16'h0012, 16'h0064, 16'h03E8, 3, 16'h0001);
        rel();
        wait_idle(100);
        chk("t1_cnt", 64'(nresp - n0), 1);

        // Illegal type.
        send(3'd7, 16'h0001, 16'h0002, 16'h0003, 1, 16'h1234);
        rel();
        wait_idle(100);

        // Type 2, done[4] pulses one cycle before done[2].
        send(3'd2, 16'h0A0A, 16'h0B0B, 16'h0C0C, 4, 16'h00AA);
        rel();
        wait_idle(100);

        // Five back-to-back, engines silent.
        n0 = nresp;
        for (int i = 0; i < 5; i++)
            send(3'(i), 16'(16'h100 + i), 16'(i), 16'(i), 0, 16'h0);
        rel();
        @(negedge clk);
        chk("full_ready", 64'(in_ready), 0);
        chk("full_busy", 64'(busy), 1);
        wait_idle(1500);
        chk("t4_cnt", 64'(nresp - n0), 5);

        // Consumer stalls 10 cycles in RESP with the queue non-empty.
        @(posedge clk);
        #1 res_ready = 1'b0;
        send(3'd1, 16'h0011, 16'h0022, 16'h0033, 2, 16'hBEEF);
        send(3'd3, 16'h0044, 16'h0055, 16'h0066, 2, 16'hCAFE);
        rel();
        n = 0;
        while (!res_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("stall_seen", 64'(res_valid), 1);
        repeat (10) @(negedge clk);
        chk("stall_valid", 64'(res_valid), 1);
        chk("stall_busy", 64'(busy), 1);
        @(posedge clk);
        #1 res_ready = 1'b1;
        wait_idle(200);

        // Random traffic with random consumer backpressure.
        rand_rdy = 1'b1;
        for (int i = 0; i < 40; i++) begin
            int r, d;
            r = $urandom_range(0, 19);
            d = (r == 0) ? 0 : (r == 1) ? 255 : $urandom_range(1, 12);
            send(3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom),
                 16'($urandom), d, 16'($urandom));
            if ($urandom_range(0, 2) == 0) begin
                rel();
                repeat ($urandom_range(1, 5)) @(posedge clk);
            end
        end
        rel();
        rand_rdy = 1'b0;
        @(posedge clk);
        #2 res_ready = 1'b1;
        wait_idle(12000);

        // Reset while the first message waits and two are queued.
        for (int i = 0; i < 3; i++)
            send(3'd3, 16'(16'h200 + i), 16'h1, 16'h2, 0, 16'h0);
        rel();
        repeat (30) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("rst_start", 64'(op_start), 0);
        chk("rst_valid", 64'(res_valid), 0);
        chk("rst_data", 64'(res_data), 0);
        chk("rst_status", 64'(res_status), 0);
        chk("rst_type", 64'(res_type), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_ready", 64'(in_ready), 1);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        n0 = nresp;
        repeat (300) @(negedge clk);
        chk("post_busy", 64'(busy), 0);
        chk("post_resp", 64'(nresp - n0), 0);

        // Still functional after reset.
        send(3'd1, 16'h0777, 16'h0888, 16'h0999, 2, 16'h55AA);
        rel();
        wait_idle(100);
        chk("post_cnt", 64'(nresp - n0), 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
